// File: rtl/ws2812_pkg.sv
// Constants and types shared by the SPI frame receiver and the WS2812 output stage.
package ws2812_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int ADDR_WIDTH   = 11;
  localparam int MAX_ADDR     = 1304;

  // Header bits that must be zero for a start address to be accepted
  localparam int HDR_RSVD_MSB = 15;
  localparam int HDR_RSVD_LSB = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    REJECT = 2'd3
  } rx_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchroniser for one asynchronous input, with a registered
// previous value so the caller gets single-cycle rise/fall pulses.
module spi_input_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_prev,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  // Shift form keeps STAGES=1 legal as well
  always_ff @(posedge clock) begin
    if (reset) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= (r_chain << 1) | STAGES'(i_async);
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_prev = r_prev;
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave: the first word of a chip-select frame is a start address,
// every following word becomes one addressed write into the WS2812 frame buffer.
module spi_frame_receiver
  import ws2812_pkg::*;
#(
  parameter int DATA_WIDTH  = ws2812_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = ws2812_pkg::ADDR_WIDTH,
  parameter int MAX_ADDR    = ws2812_pkg::MAX_ADDR,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic [DATA_WIDTH-1:0] spi_data,
  output logic [ADDR_WIDTH-1:0] spi_address,
  output logic                  spi_write_strobe,
  output logic                  frame_active,
  output logic                  frame_error
);

  localparam int                    CNT_W     = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_ADDR);

  logic w_sck_sync, w_sck_prev, w_sck_rise, w_sck_fall;
  logic w_csn_sync, w_csn_prev, w_csn_rise, w_csn_fall;
  logic w_mosi_sync, w_mosi_prev, w_mosi_rise, w_mosi_fall;
  logic w_unused_bits;

  spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clock(clock), .reset(reset), .i_async(spi_sck),
    .o_sync(w_sck_sync), .o_prev(w_sck_prev), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clock(clock), .reset(reset), .i_async(spi_cs_n),
    .o_sync(w_csn_sync), .o_prev(w_csn_prev), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clock(clock), .reset(reset), .i_async(spi_mosi),
    .o_sync(w_mosi_sync), .o_prev(w_mosi_prev), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  rx_state_t             r_state, w_state_next;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift, w_word;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_ptr_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_strobe, r_error;
  logic                  w_receiving, w_bit_act, w_word_done, w_hdr_ok;

  assign w_unused_bits = ^{w_sck_sync, w_sck_prev, w_sck_fall, w_csn_prev,
                           w_mosi_prev, w_mosi_rise, w_mosi_fall, r_shift[DATA_WIDTH-1]};

  // The CS-release cycle still admits an edge so a coincident 16th bit completes
  assign w_receiving = (r_state == HEADER) || (r_state == DATA);
  assign w_bit_act   = w_sck_rise & (~w_csn_sync | w_csn_rise) & w_receiving;
  assign w_word_done = w_bit_act & (r_bit_cnt == LAST_BIT);
  assign w_word      = {r_shift[DATA_WIDTH-2:0], w_mosi_sync};
  assign w_hdr_ok    = (w_word[HDR_RSVD_MSB:HDR_RSVD_LSB] == '0) &&
                       (w_word[ADDR_WIDTH-1:0] <= LAST_ADDR);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_csn_fall) w_state_next = HEADER;
      HEADER:  if (w_word_done) w_state_next = w_hdr_ok ? DATA : REJECT;
      DATA:    w_state_next = DATA;
      REJECT:  w_state_next = REJECT;
      default: w_state_next = IDLE;
    endcase
    if (w_csn_rise) w_state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_ptr_valid <= 1'b0;
      r_data      <= '0;
      r_addr      <= '0;
      r_strobe    <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (r_state == IDLE) begin
        r_bit_cnt <= '0;
        if (w_csn_fall) r_error <= 1'b0;
      end else if (w_bit_act) begin
        r_shift   <= w_word;
        r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + 1'b1;
      end

      if (w_word_done && r_state == HEADER) begin
        if (w_hdr_ok) begin
          r_ptr       <= w_word[ADDR_WIDTH-1:0];
          r_ptr_valid <= 1'b1;
        end else begin
          r_error <= 1'b1;
        end
      end

      // Past the last buffer word the pointer goes invalid instead of wrapping
      if (w_word_done && r_state == DATA) begin
        if (r_ptr_valid) begin
          r_data   <= w_word;
          r_addr   <= r_ptr;
          r_strobe <= 1'b1;
          if (r_ptr == LAST_ADDR) r_ptr_valid <= 1'b0;
          else                    r_ptr       <= r_ptr + 1'b1;
        end else begin
          r_error <= 1'b1;
        end
      end
    end
  end

  assign spi_data         = r_data;
  assign spi_address      = r_addr;
  assign spi_write_strobe = r_strobe;
  assign frame_active     = w_receiving;
  assign frame_error      = r_error;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Randomised frame-level bench for spi_frame_receiver with a word-level reference model.
module tb_spi_frame_receiver;

  localparam int MAXA = 1304;

  logic        clock, reset, spi_sck, spi_cs_n, spi_mosi;
  logic [15:0] spi_data;
  logic [10:0] spi_address;
  logic        spi_write_strobe, frame_active, frame_error;

  int n_checks = 0;
  int n_errors = 0;
  int frame_no = 0;

  logic [15:0] tx_words [0:7];
  logic [10:0] got_addr[$];
  logic [15:0] got_data[$];
  int          hi_cycles;
  bit          prev_strobe;
  logic [10:0] exp_addr[$];
  logic [15:0] exp_data[$];
  bit          exp_err, exp_hdr_ok;

  spi_frame_receiver dut (
    .clock(clock), .reset(reset),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_data(spi_data), .spi_address(spi_address),
    .spi_write_strobe(spi_write_strobe),
    .frame_active(frame_active), .frame_error(frame_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Capture one write per strobe rising; count every high cycle to catch wide strobes
  always @(negedge clock) begin
    if (spi_write_strobe) begin
      hi_cycles++;
      if (!prev_strobe) begin
        got_addr.push_back(spi_address);
        got_data.push_back(spi_data);
      end
    end
    prev_strobe = spi_write_strobe;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    hi_cycles = 0;
  endtask

  task automatic send_word(input logic [15:0] w, input int nbits, input int hp);
    for (int i = 0; i < nbits; i++) begin
      spi_sck  = 1'b0;
      spi_mosi = w[15-i];
      tick(hp);
      spi_sck  = 1'b1;
      tick(hp);
    end
  endtask

  task automatic end_frame(input int hp);
    spi_sck = 1'b0;
    tick(hp);
    spi_cs_n = 1'b1;
    tick(6);
  endtask

  // Reference: header picks a start address; each later word lands at the next
  // address while it is still inside the buffer, otherwise it is dropped with an error.
  task automatic model_frame(input int n_total);
    int a;
    exp_addr.delete();
    exp_data.delete();
    exp_err    = 1'b0;
    exp_hdr_ok = (tx_words[0][15:11] == 5'd0) && (int'(tx_words[0][10:0]) <= MAXA);
    if (!exp_hdr_ok) begin
      exp_err = 1'b1;
    end else begin
      a = int'(tx_words[0][10:0]);
      for (int i = 1; i < n_total; i++) begin
        if (a <= MAXA) begin
          exp_addr.push_back(11'(a));
          exp_data.push_back(tx_words[i]);
          a++;
        end else begin
          exp_err = 1'b1;
        end
      end
    end
  endtask

  task automatic check_writes();
    int n;
    check_eq("nwrites", 32'(got_addr.size()), 32'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_eq("wr_addr", 32'(got_addr[i]), 32'(exp_addr[i]));
      check_eq("wr_data", 32'(got_data[i]), 32'(exp_data[i]));
    end
    check_eq("strobe_cycles", 32'(hi_cycles), 32'(got_addr.size()));
  endtask

  task automatic send_frame(input int nw, input int partial, input int hp);
    clear_mon();
    model_frame(nw + 1);
    spi_cs_n = 1'b0;
    tick(4);
    check_eq("err_clear", 32'(frame_error), 32'd0);
    check_eq("active_start", 32'(frame_active), 32'd1);
    send_word(tx_words[0], 16, hp);
    tick(3);
    check_eq("active_hdr", 32'(frame_active), 32'(exp_hdr_ok));
    for (int i = 1; i <= nw; i++) send_word(tx_words[i], 16, hp);
    if (partial > 0) send_word(16'($urandom), partial, hp);
    end_frame(hp);
    check_writes();
    check_eq("err_end", 32'(frame_error), 32'(exp_err));
    check_eq("active_end", 32'(frame_active), 32'd0);
    $display("frame %0d hdr=0x%04h data_words=%0d partial=%0d hp=%0d writes=%0d exp_err=%0b",
             frame_no, tx_words[0], nw, partial, hp, got_addr.size(), exp_err);
    frame_no++;
  endtask

  initial begin
    int sel, nw, part, hp;
    reset    = 1'b1;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    hi_cycles = 0;
    tick(4);
    check_eq("rst_data", 32'(spi_data), 32'd0);
    check_eq("rst_addr", 32'(spi_address), 32'd0);
    check_eq("rst_strobe", 32'(spi_write_strobe), 32'd0);
    check_eq("rst_active", 32'(frame_active), 32'd0);
    check_eq("rst_error", 32'(frame_error), 32'd0);
    reset = 1'b0;
    tick(6);

    tx_words[0] = 16'h0000; tx_words[1] = 16'hA5A5; tx_words[2] = 16'h1234;
    send_frame(2, 0, 4);

    tx_words[0] = 16'h0517;
    for (int i = 1; i <= 3; i++) tx_words[i] = 16'($urandom);
    send_frame(3, 0, 3);

    tx_words[0] = 16'h8000;
    for (int i = 1; i <= 2; i++) tx_words[i] = 16'($urandom);
    send_frame(2, 0, 4);

    tx_words[0] = 16'h0010; tx_words[1] = 16'($urandom);
    send_frame(1, 9, 3);

    // Reset in the middle of a data word while CS stays low: rest of frame is ignored
    clear_mon();
    spi_cs_n = 1'b0;
    tick(4);
    send_word(16'h0010, 16, 3);
    send_word(16'hC3C3, 8, 3);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check_eq("active_after_rst", 32'(frame_active), 32'd0);
    send_word(16'hC3C3 << 8, 8, 3);
    send_word(16'h7777, 16, 3);
    end_frame(3);
    check_eq("rst_frame_writes", 32'(hi_cycles), 32'd0);
    check_eq("rst_frame_err", 32'(frame_error), 32'd0);
    $display("frame %0d reset mid-frame writes=%0d", frame_no, got_addr.size());
    frame_no++;

    tx_words[0] = 16'h0002; tx_words[1] = 16'hBEEF;
    send_frame(1, 0, 3);

    // SCK at clock/4 with CS released on the same edge as the 16th bit.
    // Pin edge -> two sync flops -> detect cycle -> strobe register: strobe is
    // high after the 3rd clock edge following the pin change, for one cycle.
    clear_mon();
    spi_cs_n = 1'b0;
    tick(4);
    send_word(16'h0100, 16, 2);
    send_word(16'h5A3C, 15, 2);
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    tick(2);
    spi_sck  = 1'b1;
    spi_cs_n = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    check_eq("lat_early", 32'(spi_write_strobe), 32'd0);
    @(posedge clock); #1;
    check_eq("lat_hit", 32'(spi_write_strobe), 32'd1);
    check_eq("lat_addr", 32'(spi_address), 32'd256);
    check_eq("lat_data", 32'(spi_data), 32'h5A3C);
    @(posedge clock); #1;
    check_eq("lat_width", 32'(spi_write_strobe), 32'd0);
    spi_sck = 1'b0;
    tick(6);
    check_eq("coinc_writes", 32'(hi_cycles), 32'd1);
    check_eq("coinc_active", 32'(frame_active), 32'd0);
    check_eq("coinc_err", 32'(frame_error), 32'd0);
    $display("frame %0d coincident cs_rise writes=%0d", frame_no, got_addr.size());
    frame_no++;

    for (int f = 0; f < 25; f++) begin
      sel  = int'($urandom_range(0, 3));
      nw   = int'($urandom_range(0, 5));
      part = int'($urandom_range(0, 15));
      hp   = int'($urandom_range(2, 4));
      case (sel)
        0:       tx_words[0] = 16'($urandom_range(0, MAXA));
        1:       tx_words[0] = 16'($urandom_range(MAXA - 4, MAXA));
        2:       tx_words[0] = {5'($urandom_range(1, 31)), 11'($urandom)};
        default: tx_words[0] = 16'($urandom_range(MAXA + 1, 2047));
      endcase
      for (int i = 1; i <= nw; i++) tx_words[i] = 16'($urandom);
      send_frame(nw, part, hp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
